// File: rtl/eoc_read_ctrl.sv
// eoc_read_ctrl: read sequencer at the far end of the end-of-column token chain.
// Waits for a settled token, strobes Read once per hit, captures the ORed
// column address/data into a one-word output register (valid/ready), and
// drives the free-running BCID bus.
// Optional build macro EOC_READ_GRAY_BCID_EN: Bcid carries a registered Gray
// code of the internal counter instead of plain binary.
module eoc_read_ctrl #(
    parameter int READ_HI_CYC = 2,
    parameter int READ_LO_CYC = 2,
    parameter int SETTLE_CYC  = 3,
    parameter int NCOL_ADDR_W = 6,
    parameter int DATA_W      = 21
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Enable,
    input  logic                          Token,
    output logic                          Read,
    input  logic [NCOL_ADDR_W-1:0]        ColAddr,
    input  logic [DATA_W-1:0]             ColData,
    output logic [5:0]                    Bcid,
    output logic [NCOL_ADDR_W+DATA_W-1:0] DataOut,
    output logic                          DataValid,
    input  logic                          DataReady,
    output logic                          Busy,
    output logic [7:0]                    EmptyReadCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_HI = 2'd1,
        READ_LO = 2'd2,
        STALL   = 2'd3
    } state_t;

    localparam logic [3:0] HI_LAST    = 4'(READ_HI_CYC - 1);
    localparam logic [3:0] LO_LAST    = 4'(READ_LO_CYC - 1);
    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYC);

    state_t     state;
    state_t     next_state;
    logic [3:0] settle_cnt;
    logic [3:0] phase_cnt;
    logic [5:0] bcid_bin;
    logic       tok_en;
    logic       out_free;
    logic       capture;
    logic       empty_word;

    // Next-state decode; a new read is only launched when the output word is free
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        tok_en     = Enable & Token;
        out_free   = ~DataValid | DataReady;
        empty_word = (ColAddr == '0) && (ColData == '0);
        case (state)
            IDLE: begin
                if (tok_en && (settle_cnt == SETTLE_MAX) && out_free) begin
                    next_state = READ_HI;
                end
            end
            READ_HI: begin
                if (phase_cnt == HI_LAST) begin
                    capture    = 1'b1;
                    next_state = Enable ? READ_LO : IDLE;
                end
            end
            READ_LO: begin
                if (phase_cnt == LO_LAST) begin
                    if (!tok_en) begin
                        next_state = IDLE;
                    end else if (out_free) begin
                        next_state = READ_HI;
                    end else begin
                        next_state = STALL;
                    end
                end
            end
            STALL: begin
                if (DataReady) begin
                    next_state = tok_en ? READ_HI : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, phase/settle counters and the registered Read strobe
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            phase_cnt  <= 4'd0;
            settle_cnt <= 4'd0;
            Read       <= 1'b0;
        end else begin
            state <= next_state;
            Read  <= (next_state == READ_HI);
            if ((next_state != state) || (state == IDLE) || (state == STALL)) begin
                phase_cnt <= 4'd0;
            end else begin
                phase_cnt <= phase_cnt + 4'd1;
            end
            if ((state == IDLE) && (next_state == IDLE) && tok_en) begin
                if (settle_cnt != SETTLE_MAX) begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
            end else begin
                settle_cnt <= 4'd0;
            end
        end
    end

    // One-word output register with valid/ready handshake and empty-read counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            DataOut      <= '0;
            DataValid    <= 1'b0;
            EmptyReadCnt <= 8'd0;
        end else begin
            if (capture) begin
                DataOut   <= {ColAddr, ColData};
                DataValid <= 1'b1;
                if (empty_word && (EmptyReadCnt != 8'hFF)) begin
                    EmptyReadCnt <= EmptyReadCnt + 8'd1;
                end
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end
        end
    end

    // Free-running BCID counter, independent of Enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcid_bin <= 6'd0;
        end else begin
            bcid_bin <= bcid_bin + 6'd1;
        end
    end

`ifdef EOC_READ_GRAY_BCID_EN
    logic [5:0] bcid_gray;
    logic [5:0] bcid_next;

    assign bcid_next = bcid_bin + 6'd1;

    // Registered Gray copy kept in step with the binary counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcid_gray <= 6'd0;
        end else begin
            bcid_gray <= bcid_next ^ (bcid_next >> 1);
        end
    end

    assign Bcid = bcid_gray;
`else
    assign Bcid = bcid_bin;
`endif

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_eoc_read_ctrl.sv
// tb_eoc_read_ctrl: directed scenarios plus randomized traffic for
// eoc_read_ctrl, compared every cycle against a behavioural model that works
// from remaining-cycle counts and a simple word register.
module tb_eoc_read_ctrl;

    localparam int HI     = 2;
    localparam int LO     = 2;
    localparam int SETTLE = 3;

    localparam int M_IDLE  = 0;
    localparam int M_HI    = 1;
    localparam int M_LO    = 2;
    localparam int M_STALL = 3;

    logic        CLK;
    logic        RST;
    logic        Enable;
    logic        Token;
    logic        Read;
    logic [5:0]  ColAddr;
    logic [20:0] ColData;
    logic [5:0]  Bcid;
    logic [26:0] DataOut;
    logic        DataValid;
    logic        DataReady;
    logic        Busy;
    logic [7:0]  EmptyReadCnt;

    int checks   = 0;
    int failures = 0;

    int          m_mode;
    int          m_settle;
    int          m_hi_left;
    int          m_lo_left;
    int          m_bcid;
    bit          m_valid;
    logic [26:0] m_dout;
    int          m_empty;
    int          m_captures;

    logic [5:0]  prev_bcid;
    bit          have_prev;

    eoc_read_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .Enable       (Enable),
        .Token        (Token),
        .Read         (Read),
        .ColAddr      (ColAddr),
        .ColData      (ColData),
        .Bcid         (Bcid),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .DataReady    (DataReady),
        .Busy         (Busy),
        .EmptyReadCnt (EmptyReadCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic tok,
                                 input logic [5:0] addr, input logic [20:0] data,
                                 input logic rdy);
        RST       = rst;
        Enable    = en;
        Token     = tok;
        ColAddr   = addr;
        ColData   = data;
        DataReady = rdy;
    endtask

    // Advance the reference by one rising edge using the inputs currently driven
    task automatic modelStep();
        bit te;
        bit free;
        bit cap;
        if (RST) begin
            m_mode    = M_IDLE;
            m_settle  = 0;
            m_hi_left = 0;
            m_lo_left = 0;
            m_bcid    = 0;
            m_valid   = 0;
            m_dout    = '0;
            m_empty   = 0;
        end else begin
            te     = Enable && Token;
            free   = !m_valid || DataReady;
            cap    = 0;
            m_bcid = (m_bcid + 1) % 64;
            case (m_mode)
                M_IDLE: begin
                    if (te && m_settle >= SETTLE && free) begin
                        m_mode    = M_HI;
                        m_hi_left = HI;
                    end else begin
                        m_settle = te ? m_settle + 1 : 0;
                    end
                end
                M_HI: begin
                    m_hi_left--;
                    if (m_hi_left == 0) begin
                        cap = 1;
                        if (Enable) begin
                            m_mode    = M_LO;
                            m_lo_left = LO;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_LO: begin
                    m_lo_left--;
                    if (m_lo_left == 0) begin
                        if (!te) begin
                            m_mode = M_IDLE;
                        end else if (free) begin
                            m_mode    = M_HI;
                            m_hi_left = HI;
                        end else begin
                            m_mode = M_STALL;
                        end
                    end
                end
                default: begin
                    if (DataReady) begin
                        if (te) begin
                            m_mode    = M_HI;
                            m_hi_left = HI;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            endcase
            if (m_mode != M_IDLE) m_settle = 0;
            if (cap) begin
                m_dout  = {ColAddr, ColData};
                m_valid = 1;
                m_captures++;
                if (ColAddr == 6'd0 && ColData == 21'd0 && m_empty < 255) m_empty++;
            end else if (m_valid && DataReady) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: update reference, then compare all outputs just after the edge
    task automatic step();
        logic [5:0] exp_bcid;
        @(posedge CLK);
        modelStep();
        #1;
`ifdef EOC_READ_GRAY_BCID_EN
        exp_bcid = 6'(m_bcid ^ (m_bcid >> 1));
`else
        exp_bcid = 6'(m_bcid);
`endif
        checkOutput("read", 32'(Read), 32'(m_mode == M_HI));
        checkOutput("busy", 32'(Busy), 32'(m_mode != M_IDLE));
        checkOutput("data_valid", 32'(DataValid), 32'(m_valid));
        checkOutput("data_out", 32'(DataOut), 32'(m_dout));
        checkOutput("empty_cnt", 32'(EmptyReadCnt), 32'(m_empty));
        checkOutput("bcid", 32'(Bcid), 32'(exp_bcid));
`ifdef EOC_READ_GRAY_BCID_EN
        if (!RST && have_prev) checkOutput("bcid_one_bit", 32'($countones(Bcid ^ prev_bcid)), 32'd1);
`endif
        prev_bcid = Bcid;
        have_prev = 1;
    endtask

    initial begin
        m_captures = 0;
        have_prev  = 0;
        prev_bcid  = 6'd0;

        // Reset held for three cycles
        applyStimulus(1, 0, 0, 6'd0, 21'd0, 1);
        repeat (3) step();
        checkOutput("reset_read", 32'(Read), 32'd0);
        checkOutput("reset_valid", 32'(DataValid), 32'd0);
        checkOutput("reset_bcid", 32'(Bcid), 32'd0);

        // Free-running BCID through a full wrap
        applyStimulus(0, 0, 0, 6'd0, 21'd0, 1);
        repeat (70) step();

        // Single hit: token high five cycles
        applyStimulus(0, 1, 1, 6'd5, 21'h1ABCD, 1);
        repeat (5) step();
        applyStimulus(0, 1, 0, 6'd5, 21'h1ABCD, 1);
        step();
        checkOutput("single_word", 32'(DataOut), 32'({6'd5, 21'h1ABCD}));
        checkOutput("single_valid", 32'(DataValid), 32'd1);
        repeat (10) step();

        // Three back-to-back hits with addresses 1,2,3
        m_captures = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(0, 1, 1, 6'(m_captures + 1), 21'h00100 + 21'(k), 1);
            step();
        end
        applyStimulus(0, 1, 0, 6'd0, 21'd0, 1);
        repeat (8) step();

        // Two-hit burst with sink back-pressure for ten cycles
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 1, 6'd9 + 6'(k), 21'h0F0F0, (k >= 10));
            step();
        end
        applyStimulus(0, 1, 0, 6'd0, 21'd0, 1);
        repeat (8) step();

        // Short token pulse and disabled readout never produce a read
        applyStimulus(0, 1, 1, 6'd7, 21'd7, 1);
        repeat (2) step();
        applyStimulus(0, 1, 0, 6'd7, 21'd7, 1);
        repeat (4) step();
        applyStimulus(0, 0, 1, 6'd7, 21'd7, 1);
        repeat (10) step();
        checkOutput("disabled_busy", 32'(Busy), 32'd0);
        applyStimulus(0, 1, 0, 6'd0, 21'd0, 1);
        repeat (4) step();

        // Reset during the second Read-high cycle
        applyStimulus(0, 1, 1, 6'd3, 21'h33, 1);
        repeat (5) step();
        checkOutput("mid_read_high", 32'(Read), 32'd1);
        applyStimulus(1, 1, 1, 6'd3, 21'h33, 1);
        step();
        checkOutput("mid_reset_read", 32'(Read), 32'd0);
        checkOutput("mid_reset_valid", 32'(DataValid), 32'd0);

        // Empty reads: first one counts, then saturation
        applyStimulus(0, 1, 1, 6'd0, 21'd0, 1);
        repeat (8) step();
        checkOutput("empty_first", 32'(EmptyReadCnt), 32'd1);
        repeat (1300) step();
        checkOutput("empty_saturate", 32'(EmptyReadCnt), 32'd255);

        // Randomized traffic
        applyStimulus(0, 1, 0, 6'd0, 21'd0, 1);
        for (int k = 0; k < 3000; k++) begin
            logic tok;
            tok = Token;
            if ($urandom_range(0, 5) == 0) tok = ~tok;
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0),
                              tok, 6'd0, 21'd0, ($urandom_range(0, 99) < 60));
            end else begin
                applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0),
                              tok, 6'($urandom()), 21'($urandom()), ($urandom_range(0, 99) < 60));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eoc_read_ctrl.md
Name: eoc_read_ctrl

Overview:
- Chip-periphery read sequencer at the far end of the end-of-column token chain.
- Watches the chain's output token and strobes the shared Read line to pull one hit at a time.
- Samples the ORed column address/data bus per hit and hands words to the output FIFO via valid/ready.
- Drives the free-running 6-bit BCID bus distributed to all EOCs.

Parameters:
- READ_HI_CYC, 2, cycles Read is held high per hit; data sampled on the last of them; range 1..15
- READ_LO_CYC, 2, cycles Read is held low after each hit for token re-ripple; range 1..15
- SETTLE_CYC, 3, cycles the token must stay high in IDLE before the first Read; range 1..15
- NCOL_ADDR_W, 6, column address width
- DATA_W, 21, column data width

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- Enable  in  1  readout enable
- Token  in  1  token from last EOC of chain (chain TokOutChip)
- Read  out  1  read strobe to all EOCs
- ColAddr  in  6  ORed column address bus
- ColData  in  21  ORed column data bus
- Bcid  out  6  BCID bus to EOCs
- DataOut  out  27  {ColAddr, ColData}, addr in [26:21]
- DataValid  out  1  DataOut holds an unread word
- DataReady  in  1  sink accepts when DataValid & DataReady
- Busy  out  1  state != IDLE
- EmptyReadCnt  out  8  saturating count of reads returning addr==0 and data==0

Behaviour:
- Clock and reset: one clock CLK; reset RST synchronous, active-high, sampled on rising CLK edge.
- Reset values: Read=0, Bcid=0, DataOut=0, DataValid=0, EmptyReadCnt=0, Busy=0, state IDLE, all cycle counters 0.
- Reset mid-read: Read falls on the same edge and the held word is discarded.
- Bcid: increments every cycle; wraps 63->0; independent of Enable.
- Read is registered and glitch-free. It toggles only on state entry/exit.

States:
- IDLE: Read=0.
  - Settle counter counts consecutive cycles with Enable & Token; cleared otherwise.
  - When it reaches SETTLE_CYC and (!DataValid | DataReady), go to READ_HI.
- READ_HI: Read=1 for exactly READ_HI_CYC cycles.
  - On the last cycle: DataOut<={ColAddr,ColData}, DataValid<=1, then go to READ_LO.
  - If the sampled addr and data are both 0, EmptyReadCnt increments, saturating at 255. The word is still emitted.
- READ_LO: Read=0 for exactly READ_LO_CYC cycles. At the end:
  - !Token or !Enable -> IDLE, with the settle counter cleared.
  - Token & Enable & (!DataValid | DataReady) -> READ_HI.
  - Token & Enable & DataValid & !DataReady -> STALL.
- STALL: Read=0; Token is not re-checked for settle.
  - When DataReady -> READ_HI if Token & Enable, else IDLE.

Handshake and timing:
- A word is consumed on any edge with DataValid & DataReady. DataValid clears unless a new capture happens on the same edge, in which case it stays 1 with the new word.
- Output holds one word only; a read is never issued that could overwrite an unaccepted word.
- Minimum per-hit period is READ_HI_CYC+READ_LO_CYC cycles (4 at defaults).
- Enable dropping during READ_HI: the strobe completes and the word is captured, then IDLE.
- Token dropping during READ_HI is ignored; Token is only evaluated at the end of READ_LO and in IDLE/STALL.

Optional Feature:
- Macro: EOC_READ_GRAY_BCID_EN.
- Defined: Bcid carries Gray code of the internal binary counter (b ^ (b>>1)), registered, so exactly one bit changes per cycle including the 63->0 wrap. Reset value 0.
- Undefined: Bcid is the plain binary counter.
- Readout state machine is identical in both builds.

Test Plan:
- Reset, hold RST 3 cycles -> Read=0, DataValid=0, Bcid=0; after release Bcid reads 1,2,3...; after 64 cycles wraps to 0; Gray build shows one-bit changes only.
- Token held high 5 cycles with Enable=1, ColAddr=6'd5, ColData=21'h1ABCD, DataReady=1 -> Read rises 3 cycles after Token, high 2 cycles; DataOut={6'd5,21'h1ABCD} with DataValid for 1 cycle; Read low 2 cycles, then back to IDLE when Token=0.
- Token high for 3 consecutive hits (addr 1,2,3), DataReady=1 -> three Read pulses at 4-cycle period; DataOut sequence 1,2,3.
- DataReady=0 for 10 cycles during 2-hit burst -> after first word Read stays 0 (STALL) and DataOut is stable; the second Read starts on the cycle after DataReady asserts.
- Token pulses high 2 cycles only (< SETTLE_CYC) -> no Read, Busy stays 0; Enable=0 with Token=1 -> no Read.
- RST asserted in the 2nd READ_HI cycle -> Read=0 and DataValid=0 on the next edge; read with ColAddr=0 and ColData=0 -> EmptyReadCnt=1; 300 such reads -> EmptyReadCnt=255.
